mm_bus_arbiter: RTL and testbench

//   Two-requester arbiter sharing one pCPU memory-mapped bus port (a/d/we/rd/spo/ready),

---
 rtl/mm_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_mm_bus_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_bus_arbiter.sv
// Two-requester arbiter for one memory-mapped bus port: latches the winning request,
// replays it downstream until s_ready, and routes data/ready back to the owner only.
// Optional abort of stuck transactions when ARB_TIMEOUT_EN is defined.
module mm_bus_arbiter #(
  parameter int PRIO_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  input  logic        m0_rd,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  input  logic        m1_rd,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic [31:0] s_a,
  output logic [31:0] s_d,
  output logic        s_we,
  output logic        s_rd,
  input  logic [31:0] s_spo,
  input  logic        s_ready,
  output logic [1:0]  grant,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mm_bus_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  state_t      state;
  logic        prefer_m1;
  logic        req0;
  logic        req1;
  logic        pick_m1;
  logic        finish;
  logic        expired;
  logic [31:0] finish_data;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] busy_cnt;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    req0    = m0_we | m0_rd;
    req1    = m1_we | m1_rd;
    pick_m1 = 1'b0;
    if (req1 && !req0)
      pick_m1 = 1'b1;
    else if (req1 && req0 && PRIO_MODE == 0)
      pick_m1 = prefer_m1;
  end

  // s_ready on the expiry cycle takes precedence over the abort.
  always_comb begin
    finish      = s_ready;
    expired     = 1'b0;
    finish_data = s_spo;
`ifdef ARB_TIMEOUT_EN
    if (!s_ready && busy_cnt == TIMEOUT_LAST) begin
      finish      = 1'b1;
      expired     = 1'b1;
      finish_data = 32'hFFFF_FFFF;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prefer_m1 <= 1'b0;
      s_a       <= '0;
      s_d       <= '0;
      s_we      <= 1'b0;
      s_rd      <= 1'b0;
      grant     <= 2'b00;
      m0_spo    <= '0;
      m1_spo    <= '0;
      m0_ready  <= 1'b0;
      m1_ready  <= 1'b0;
      timeout   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      busy_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            // A requester raising both we and rd is served as a write.
            if (pick_m1) begin
              s_a       <= m1_a;
              s_d       <= m1_d;
              s_we      <= m1_we;
              s_rd      <= m1_rd & ~m1_we;
              grant     <= 2'b10;
              prefer_m1 <= 1'b0;
            end else begin
              s_a       <= m0_a;
              s_d       <= m0_d;
              s_we      <= m0_we;
              s_rd      <= m0_rd & ~m0_we;
              grant     <= 2'b01;
              prefer_m1 <= 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            busy_cnt <= '0;
`endif
            state <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            s_we    <= 1'b0;
            s_rd    <= 1'b0;
            timeout <= expired;
            if (grant[1]) begin
              m1_spo   <= finish_data;
              m1_ready <= 1'b1;
            end else begin
              m0_spo   <= finish_data;
              m0_ready <= 1'b1;
            end
            state <= DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            busy_cnt <= busy_cnt + 16'd1;
          end
`endif
        end
        DONE: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          timeout  <= 1'b0;
          grant    <= 2'b00;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Directed bench for mm_bus_arbiter: round-robin and fixed-priority instances share
// all inputs and are checked against hand-computed expectations.
module tb_mm_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_a, m0_d, m1_a, m1_d, s_spo;
  logic        m0_we, m0_rd, m1_we, m1_rd, s_ready;

  logic [31:0] rr_m0_spo, rr_m1_spo, rr_s_a, rr_s_d;
  logic        rr_m0_ready, rr_m1_ready, rr_s_we, rr_s_rd, rr_timeout;
  logic [1:0]  rr_grant;
  logic [31:0] fx_m0_spo, fx_m1_spo, fx_s_a, fx_s_d;
  logic        fx_m0_ready, fx_m1_ready, fx_s_we, fx_s_rd, fx_timeout;
  logic [1:0]  fx_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mm_bus_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYCLES(8)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
    .m0_spo(rr_m0_spo), .m0_ready(rr_m0_ready),
    .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
    .m1_spo(rr_m1_spo), .m1_ready(rr_m1_ready),
    .s_a(rr_s_a), .s_d(rr_s_d), .s_we(rr_s_we), .s_rd(rr_s_rd),
    .s_spo(s_spo), .s_ready(s_ready),
    .grant(rr_grant), .timeout(rr_timeout)
  );

  mm_bus_arbiter #(.PRIO_MODE(1), .TIMEOUT_CYCLES(8)) dut_fx (
    .clk(clk), .rst(rst),
    .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
    .m0_spo(fx_m0_spo), .m0_ready(fx_m0_ready),
    .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
    .m1_spo(fx_m1_spo), .m1_ready(fx_m1_ready),
    .s_a(fx_s_a), .s_d(fx_s_d), .s_we(fx_s_we), .s_rd(fx_s_rd),
    .s_spo(s_spo), .s_ready(s_ready),
    .grant(fx_grant), .timeout(fx_timeout)
  );

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_a = '0; m0_d = '0; m0_we = 1'b0; m0_rd = 1'b0;
    m1_a = '0; m1_d = '0; m1_we = 1'b0; m1_rd = 1'b0;
    s_spo = '0; s_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #12;
    checks++;
    if ({rr_grant, rr_s_we, rr_s_rd, rr_m0_ready, rr_m1_ready, rr_timeout} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl_rr: got grant=%b we=%b rd=%b rdy=%b%b to=%b, expected all 0",
               rr_grant, rr_s_we, rr_s_rd, rr_m0_ready, rr_m1_ready, rr_timeout);
    end
    checks++;
    if ({rr_s_a, rr_s_d, rr_m0_spo, rr_m1_spo} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data_rr: got s_a=%h s_d=%h spo0=%h spo1=%h, expected all 0",
               rr_s_a, rr_s_d, rr_m0_spo, rr_m1_spo);
    end
    checks++;
    if ({fx_grant, fx_s_we, fx_s_rd, fx_m0_ready, fx_m1_ready, fx_timeout, fx_s_a, fx_m0_spo} !== '0) begin
      errors++;
      $display("FAIL reset_fx: got grant=%b s_a=%h spo0=%h, expected 0", fx_grant, fx_s_a, fx_m0_spo);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_read();
    m0_rd = 1'b1;
    m0_a  = 32'h8000_0010;
    cyc();
    checks++;
    if (rr_grant !== 2'b01 || rr_s_rd !== 1'b1 || rr_s_we !== 1'b0 || rr_s_a !== 32'h8000_0010) begin
      errors++;
      $display("FAIL read_issue: got grant=%b rd=%b we=%b s_a=%h, expected 01 1 0 80000010",
               rr_grant, rr_s_rd, rr_s_we, rr_s_a);
    end
    cyc();
    cyc();
    cyc();
    s_ready = 1'b1;
    s_spo   = 32'h1234_5678;
    checks++;
    if (rr_m0_ready !== 1'b0 || rr_s_rd !== 1'b1) begin
      errors++;
      $display("FAIL read_wait: got m0_ready=%b s_rd=%b, expected 0 1", rr_m0_ready, rr_s_rd);
    end
    cyc();
    s_ready = 1'b0;
    m0_rd   = 1'b0;
    checks++;
    if (rr_m0_ready !== 1'b1 || rr_m1_ready !== 1'b0 || rr_m0_spo !== 32'h1234_5678 || rr_grant !== 2'b01) begin
      errors++;
      $display("FAIL read_done: got rdy0=%b rdy1=%b spo=%h grant=%b, expected 1 0 12345678 01",
               rr_m0_ready, rr_m1_ready, rr_m0_spo, rr_grant);
    end
    checks++;
    if (rr_s_rd !== 1'b0 || rr_timeout !== 1'b0 || fx_m0_spo !== 32'h1234_5678 || fx_m0_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_done2: got s_rd=%b to=%b fx_spo=%h fx_rdy=%b, expected 0 0 12345678 1",
               rr_s_rd, rr_timeout, fx_m0_spo, fx_m0_ready);
    end
    // A stray s_ready while idle must not complete anything or disturb spo.
    s_ready = 1'b1;
    s_spo   = 32'hDEAD_BEEF;
    cyc();
    s_ready = 1'b0;
    checks++;
    if (rr_grant !== 2'b00 || rr_m0_ready !== 1'b0 || rr_m0_spo !== 32'h1234_5678 || rr_m1_spo !== 32'h0) begin
      errors++;
      $display("FAIL read_idle: got grant=%b rdy=%b spo0=%h spo1=%h, expected 00 0 12345678 0",
               rr_grant, rr_m0_ready, rr_m0_spo, rr_m1_spo);
    end
    cyc();
    checks++;
    if (rr_grant !== 2'b00 || rr_m0_ready !== 1'b0 || rr_s_rd !== 1'b0) begin
      errors++;
      $display("FAIL read_idle2: got grant=%b rdy=%b s_rd=%b, expected 00 0 0",
               rr_grant, rr_m0_ready, rr_s_rd);
    end
  endtask

  // One complete transaction starting in IDLE with both requests held.
  task automatic serve(input logic exp_rr_m1, input logic exp_fx_m1, input logic [31:0] rsp);
    logic [31:0] rr_a, fx_a, rr_d;
    rr_a = exp_rr_m1 ? m1_a : m0_a;
    rr_d = exp_rr_m1 ? m1_d : m0_d;
    fx_a = exp_fx_m1 ? m1_a : m0_a;
    cyc();
    checks++;
    if (rr_grant !== (exp_rr_m1 ? 2'b10 : 2'b01) || rr_s_a !== rr_a || rr_s_d !== rr_d || rr_s_we !== 1'b1) begin
      errors++;
      $display("FAIL rr_grant: got grant=%b s_a=%h s_d=%h we=%b, expected m1=%b s_a=%h s_d=%h we=1",
               rr_grant, rr_s_a, rr_s_d, rr_s_we, exp_rr_m1, rr_a, rr_d);
    end
    checks++;
    if (fx_grant !== (exp_fx_m1 ? 2'b10 : 2'b01) || fx_s_a !== fx_a) begin
      errors++;
      $display("FAIL fx_grant: got grant=%b s_a=%h, expected m1=%b s_a=%h",
               fx_grant, fx_s_a, exp_fx_m1, fx_a);
    end
    s_spo   = rsp;
    s_ready = 1'b1;
    cyc();
    s_ready = 1'b0;
    checks++;
    if (rr_m1_ready !== exp_rr_m1 || rr_m0_ready !== !exp_rr_m1 ||
        (exp_rr_m1 ? rr_m1_spo : rr_m0_spo) !== rsp || rr_s_we !== 1'b0) begin
      errors++;
      $display("FAIL rr_done: got rdy1=%b rdy0=%b spo0=%h spo1=%h we=%b, expected m1=%b spo=%h we=0",
               rr_m1_ready, rr_m0_ready, rr_m0_spo, rr_m1_spo, rr_s_we, exp_rr_m1, rsp);
    end
    checks++;
    if (fx_m1_ready !== exp_fx_m1 || fx_m0_ready !== !exp_fx_m1 ||
        (exp_fx_m1 ? fx_m1_spo : fx_m0_spo) !== rsp) begin
      errors++;
      $display("FAIL fx_done: got rdy1=%b rdy0=%b spo0=%h spo1=%h, expected m1=%b spo=%h",
               fx_m1_ready, fx_m0_ready, fx_m0_spo, fx_m1_spo, exp_fx_m1, rsp);
    end
    cyc();
  endtask

  task automatic test_contention();
    test_reset();
    m0_we = 1'b1; m0_a = 32'h0000_0100; m0_d = 32'h0000_AAAA;
    m1_we = 1'b1; m1_a = 32'h0000_0200; m1_d = 32'h0000_BBBB;
    serve(1'b0, 1'b0, 32'h0000_0001);
    serve(1'b1, 1'b0, 32'h0000_0002);
    serve(1'b0, 1'b0, 32'h0000_0003);
    serve(1'b1, 1'b0, 32'h0000_0004);
    m0_we = 1'b0;
    m1_we = 1'b0;
    cyc();
  endtask

  task automatic test_we_rd_hold();
    test_reset();
    m1_we = 1'b1; m1_rd = 1'b1; m1_a = 32'h0000_0010; m1_d = 32'h0000_00A5;
    cyc();
    checks++;
    if (rr_s_we !== 1'b1 || rr_s_rd !== 1'b0 || rr_s_d !== 32'h0000_00A5 ||
        rr_s_a !== 32'h0000_0010 || rr_grant !== 2'b10) begin
      errors++;
      $display("FAIL we_rd_issue: got we=%b rd=%b s_d=%h s_a=%h grant=%b, expected 1 0 a5 10 10",
               rr_s_we, rr_s_rd, rr_s_d, rr_s_a, rr_grant);
    end
    m1_a  = 32'h0000_0999;
    m1_d  = 32'h0000_0555;
    m0_rd = 1'b1;
    m0_a  = 32'h0000_0777;
    cyc();
    checks++;
    if (rr_s_a !== 32'h0000_0010 || rr_s_d !== 32'h0000_00A5 || rr_grant !== 2'b10 || fx_grant !== 2'b10) begin
      errors++;
      $display("FAIL busy_hold: got s_a=%h s_d=%h grant=%b fx_grant=%b, expected 10 a5 10 10",
               rr_s_a, rr_s_d, rr_grant, fx_grant);
    end
    s_spo   = 32'h0BAD_F00D;
    s_ready = 1'b1;
    cyc();
    s_ready = 1'b0;
    m0_rd = 1'b0; m1_we = 1'b0; m1_rd = 1'b0;
    checks++;
    if (rr_m1_ready !== 1'b1 || rr_m0_ready !== 1'b0 || rr_m1_spo !== 32'h0BAD_F00D || rr_m0_spo !== 32'h0) begin
      errors++;
      $display("FAIL we_rd_done: got rdy1=%b rdy0=%b spo1=%h spo0=%h, expected 1 0 0badf00d 0",
               rr_m1_ready, rr_m0_ready, rr_m1_spo, rr_m0_spo);
    end
    cyc();
    checks++;
    if (rr_grant !== 2'b00 || rr_m1_ready !== 1'b0 || rr_s_we !== 1'b0) begin
      errors++;
      $display("FAIL we_rd_idle: got grant=%b rdy1=%b we=%b, expected 00 0 0", rr_grant, rr_m1_ready, rr_s_we);
    end
  endtask

  task automatic test_reset_mid_busy();
    m0_rd = 1'b1;
    m0_a  = 32'h0000_0044;
    cyc();
    checks++;
    if (rr_s_rd !== 1'b1 || rr_grant !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset: got s_rd=%b grant=%b, expected 1 01", rr_s_rd, rr_grant);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rr_s_rd !== 1'b0 || rr_grant !== 2'b00 || fx_s_rd !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got s_rd=%b grant=%b fx_s_rd=%b, expected 0 00 0", rr_s_rd, rr_grant, fx_s_rd);
    end
    m0_rd   = 1'b0;
    s_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (rr_m0_ready !== 1'b0 || rr_m1_ready !== 1'b0 || rr_s_rd !== 1'b0 || rr_grant !== 2'b00) begin
        errors++;
        $display("FAIL post_reset: cycle %0d got rdy=%b%b s_rd=%b grant=%b, expected 00 0 00",
                 i, rr_m0_ready, rr_m1_ready, rr_s_rd, rr_grant);
      end
    end
    s_ready = 1'b0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    test_reset();
    m0_rd = 1'b1; m0_a = 32'h0000_0300;
    m1_rd = 1'b1; m1_a = 32'h0000_0400;
    n = 0;
    while (n < 20 && rr_m0_ready !== 1'b1) begin
      cyc();
      n++;
    end
    m0_rd = 1'b0;
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL timeout_latency: got ready after %0d cycles, expected 9", n);
    end
    checks++;
    if (rr_timeout !== 1'b1 || rr_m0_spo !== 32'hFFFF_FFFF || rr_m1_ready !== 1'b0 || fx_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: got to=%b spo=%h rdy1=%b fx_to=%b, expected 1 ffffffff 0 1",
               rr_timeout, rr_m0_spo, rr_m1_ready, fx_timeout);
    end
    cyc();
    checks++;
    if (rr_timeout !== 1'b0 || rr_m0_ready !== 1'b0 || rr_grant !== 2'b00) begin
      errors++;
      $display("FAIL timeout_clear: got to=%b rdy=%b grant=%b, expected 0 0 00", rr_timeout, rr_m0_ready, rr_grant);
    end
    cyc();
    checks++;
    if (rr_grant !== 2'b10 || rr_s_a !== 32'h0000_0400 || rr_s_rd !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next: got grant=%b s_a=%h rd=%b, expected 10 400 1", rr_grant, rr_s_a, rr_s_rd);
    end
    s_spo = 32'h5555_0000; s_ready = 1'b1;
    cyc();
    s_ready = 1'b0; m1_rd = 1'b0;
    checks++;
    if (rr_m1_ready !== 1'b1 || rr_m1_spo !== 32'h5555_0000 || rr_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_m1: got rdy1=%b spo1=%h to=%b, expected 1 55550000 0", rr_m1_ready, rr_m1_spo, rr_timeout);
    end
    cyc();
  endtask
`else
  task automatic test_no_timeout();
    test_reset();
    m0_rd = 1'b1; m0_a = 32'h0000_0300;
    for (int i = 0; i < 40; i++) cyc();
    checks++;
    if (rr_m0_ready !== 1'b0 || rr_timeout !== 1'b0 || rr_s_rd !== 1'b1 || rr_grant !== 2'b01) begin
      errors++;
      $display("FAIL long_busy: got rdy=%b to=%b s_rd=%b grant=%b, expected 0 0 1 01",
               rr_m0_ready, rr_timeout, rr_s_rd, rr_grant);
    end
    s_spo = 32'h0000_CAFE; s_ready = 1'b1;
    cyc();
    s_ready = 1'b0; m0_rd = 1'b0;
    checks++;
    if (rr_m0_ready !== 1'b1 || rr_m0_spo !== 32'h0000_CAFE || rr_timeout !== 1'b0) begin
      errors++;
      $display("FAIL long_done: got rdy=%b spo=%h to=%b, expected 1 0000cafe 0", rr_m0_ready, rr_m0_spo, rr_timeout);
    end
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_we_rd_hold();
    test_reset_mid_busy();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
